pipeline_sequencer: RTL and testbench

Central hazard and stall controller for the 5-stage pipeline. Generates the enable/flush pair for each of the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. Inputs are cache hit signals, the load-use hazard, jump and branch resolution, and halt. It also runs the halt-drain sequence, a memory-wait watchdog and a stall performance counter.

---
 rtl/pipeline_ctrl_pkg.sv | 27 ++
 rtl/pipeline_sequencer_hazard_detect.sv | 17 +
 rtl/pipeline_sequencer.sv | 148 ++++++++++++++
 tb/tb_pipeline_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states, register indices and the latch control bundle.
// Pure type/constant package, no logic.
package pipeline_ctrl_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALTED} seq_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  localparam ctrl_t CTRL_FLOW = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                                  memwb_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0,
                                  exmem_flush: 1'b0, memwb_flush: 1'b0};

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use hazard compare between the EX-stage load and the ID-stage sources.
// Purely combinational, zero latency; no flow control.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic     idex_dREN,
  input  regbits_t idex_rw,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  output logic     loaduse
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign loaduse = idex_dREN && (idex_rw != '0) &&
                   ((idex_rw == ifid_rs) || (idex_rw == ifid_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// Hazard/stall controller: latch enables and flushes, PC enable, halt drain, memory watchdog, stall counter.
// Controls are combinational from registered state and live inputs; state, watchdog and counter update per CLK.
module pipeline_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             exmem_branch_taken,
  input  logic             exmem_halt,
  input  logic             id_jump,
  input  logic             idex_dREN,
  input  regbits_t         idex_rw,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  seq_state_t        state, state_n;
  ctrl_t             ctrl;
  logic              loaduse;
  logic              dstall;
  logic              run_dstall;
  logic [WAIT_W-1:0] wait_cnt;

  hazard_detect u_hazard_detect (
    .idex_dREN (idex_dREN),
    .idex_rw   (idex_rw),
    .ifid_rs   (ifid_rs),
    .ifid_rt   (ifid_rt),
    .loaduse   (loaduse)
  );

  assign dstall     = (exmem_dREN || exmem_dWEN) && !dhit;
  assign run_dstall = (state == RUN) && dstall;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= BOOT;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    ctrl    = CTRL_IDLE;
    halt    = 1'b0;
    case (state)
      BOOT: begin
        ctrl.ifid_flush  = 1'b1;
        ctrl.idex_flush  = 1'b1;
        ctrl.exmem_flush = 1'b1;
        ctrl.memwb_flush = 1'b1;
        state_n          = RUN;
      end
      RUN: begin
        ctrl = CTRL_FLOW;
        if (dstall) begin
          // Freeze the front, bubble into WB so the MEM instruction retires exactly once.
          ctrl.pc_en       = 1'b0;
          ctrl.ifid_en     = 1'b0;
          ctrl.idex_en     = 1'b0;
          ctrl.exmem_en    = 1'b0;
          ctrl.memwb_flush = 1'b1;
        end else if (exmem_halt) begin
          ctrl.pc_en       = 1'b0;
          ctrl.ifid_flush  = 1'b1;
          ctrl.idex_flush  = 1'b1;
          ctrl.exmem_flush = 1'b1;
          state_n          = DRAIN;
        end else if (exmem_branch_taken) begin
          ctrl.ifid_flush  = 1'b1;
          ctrl.idex_flush  = 1'b1;
          ctrl.exmem_flush = 1'b1;
        end else if (loaduse) begin
          ctrl.pc_en      = 1'b0;
          ctrl.ifid_en    = 1'b0;
          ctrl.idex_flush = 1'b1;
        end else if (!ihit) begin
          ctrl.pc_en      = 1'b0;
          ctrl.ifid_flush = 1'b1;
        end else if (id_jump) begin
          ctrl.ifid_flush = 1'b1;
        end
      end
      DRAIN: begin
        ctrl.memwb_en    = 1'b1;
        ctrl.ifid_flush  = 1'b1;
        ctrl.idex_flush  = 1'b1;
        ctrl.exmem_flush = 1'b1;
        state_n          = HALTED;
      end
      HALTED: begin
        halt = 1'b1;
      end
      default: begin
        state_n = BOOT;
      end
    endcase
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign idex_en     = ctrl.idex_en;
  assign exmem_en    = ctrl.exmem_en;
  assign memwb_en    = ctrl.memwb_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_flush = ctrl.memwb_flush;

  // Watchdog: saturating count of consecutive data-stall cycles; the flag is sticky.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (run_dstall) begin
      if (wait_cnt == WAIT_LAST) mem_timeout <= 1'b1;
      else                       wait_cnt    <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                           stall_count <= '0;
    else if (state == RUN && !ctrl.pc_en) stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer with a short watchdog (TIMEOUT=4).
// Inputs change on the falling edge; outputs are sampled 2 time units later.
module tb_pipeline_sequencer;
  import pipeline_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit, dhit, exmem_dREN, exmem_dWEN, exmem_branch_taken, exmem_halt, id_jump, idex_dREN;
  regbits_t    idex_rw, ifid_rs, ifid_rt;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        halt, mem_timeout;
  logic [31:0] stall_count;
  logic [8:0]  ctl;

  int vectors = 0;
  int miscompares = 0;

  // {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush}
  localparam logic [8:0] C_BOOT   = 9'b0_0000_1111;
  localparam logic [8:0] C_FLOW   = 9'b1_1111_0000;
  localparam logic [8:0] C_DSTALL = 9'b0_0001_0001;
  localparam logic [8:0] C_HALTIN = 9'b0_1111_1110;
  localparam logic [8:0] C_BRANCH = 9'b1_1111_1110;
  localparam logic [8:0] C_LOADU  = 9'b0_0111_0100;
  localparam logic [8:0] C_NOIHIT = 9'b0_1111_1000;
  localparam logic [8:0] C_JUMP   = 9'b1_1111_1000;
  localparam logic [8:0] C_DRAIN  = 9'b0_0001_1110;
  localparam logic [8:0] C_HALTED = 9'b0_0000_0000;

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush};

  always #5 CLK = ~CLK;

  pipeline_sequencer #(.TIMEOUT(4), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
    .exmem_branch_taken(exmem_branch_taken), .exmem_halt(exmem_halt),
    .id_jump(id_jump), .idex_dREN(idex_dREN), .idex_rw(idex_rw),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .halt(halt), .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
    exmem_branch_taken = 1'b0; exmem_halt = 1'b0; id_jump = 1'b0;
    idex_dREN = 1'b0; idex_rw = '0; ifid_rs = '0; ifid_rt = '0;
  endtask

  // Leaves the bench at a falling edge with the DUT in its first RUN cycle.
  task automatic do_reset();
    @(negedge CLK);
    idle_inputs();
    RST = 1'b1;
    #2;
    vectors++;
    if (ctl !== C_BOOT) begin miscompares++; $display("FAIL rst_ctl got %b want %b", ctl, C_BOOT); end
    vectors++;
    if ({halt, mem_timeout, stall_count} !== 34'd0) begin
      miscompares++; $display("FAIL rst_regs got halt=%b to=%b cnt=%0d want 0 0 0", halt, mem_timeout, stall_count);
    end
    @(negedge CLK);
    RST = 1'b0;
    #2;
    vectors++;
    if (ctl !== C_BOOT) begin miscompares++; $display("FAIL boot_cycle got %b want %b", ctl, C_BOOT); end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    vectors++;
    if (ctl !== C_FLOW) begin miscompares++; $display("FAIL run_first got %b want %b", ctl, C_FLOW); end
    vectors++;
    if (halt !== 1'b0) begin miscompares++; $display("FAIL run_halt got %b want 0", halt); end
    @(negedge CLK);
  endtask

  task automatic test_data_stall();
    do_reset();
    exmem_dREN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      vectors++;
      if (ctl !== C_DSTALL) begin miscompares++; $display("FAIL dstall_%0d got %b want %b", i, ctl, C_DSTALL); end
      @(negedge CLK);
    end
    dhit = 1'b1;
    #2;
    vectors++;
    if (ctl !== C_FLOW) begin miscompares++; $display("FAIL dhit_release got %b want %b", ctl, C_FLOW); end
    vectors++;
    if (stall_count !== 32'd3) begin miscompares++; $display("FAIL stall_count got %0d want 3", stall_count); end
    @(negedge CLK);
    idle_inputs();
    exmem_dWEN = 1'b1;
    #2;
    vectors++;
    if (ctl !== C_DSTALL) begin miscompares++; $display("FAIL dstall_store got %b want %b", ctl, C_DSTALL); end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_loaduse();
    do_reset();
    idex_dREN = 1'b1; idex_rw = 5'd5; ifid_rt = 5'd5; ifid_rs = 5'd1;
    #2;
    vectors++;
    if (ctl !== C_LOADU) begin miscompares++; $display("FAIL loaduse_rt got %b want %b", ctl, C_LOADU); end
    @(negedge CLK);
    idex_rw = 5'd0; ifid_rt = 5'd0; ifid_rs = 5'd0;
    #2;
    vectors++;
    if (ctl !== C_FLOW) begin miscompares++; $display("FAIL loaduse_r0 got %b want %b", ctl, C_FLOW); end
    @(negedge CLK);
    idex_rw = 5'd7; ifid_rs = 5'd7; ifid_rt = 5'd3; ihit = 1'b0;
    #2;
    vectors++;
    if (ctl !== C_LOADU) begin miscompares++; $display("FAIL loaduse_rs got %b want %b", ctl, C_LOADU); end
    @(negedge CLK);
    idex_dREN = 1'b0;
    #2;
    vectors++;
    if (ctl !== C_NOIHIT) begin miscompares++; $display("FAIL no_load got %b want %b", ctl, C_NOIHIT); end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_branch_jump();
    do_reset();
    ihit = 1'b0; exmem_branch_taken = 1'b1;
    #2;
    vectors++;
    if (ctl !== C_BRANCH) begin miscompares++; $display("FAIL branch got %b want %b", ctl, C_BRANCH); end
    @(negedge CLK);
    exmem_dREN = 1'b1;
    #2;
    vectors++;
    if (ctl !== C_DSTALL) begin miscompares++; $display("FAIL branch_dstall got %b want %b", ctl, C_DSTALL); end
    @(negedge CLK);
    idle_inputs();
    id_jump = 1'b1;
    #2;
    vectors++;
    if (ctl !== C_JUMP) begin miscompares++; $display("FAIL jump got %b want %b", ctl, C_JUMP); end
    @(negedge CLK);
    ihit = 1'b0;
    #2;
    vectors++;
    if (ctl !== C_NOIHIT) begin miscompares++; $display("FAIL jump_noihit got %b want %b", ctl, C_NOIHIT); end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_halt();
    do_reset();
    exmem_halt = 1'b1; exmem_dREN = 1'b1;
    #2;
    vectors++;
    if (ctl !== C_DSTALL) begin miscompares++; $display("FAIL halt_dstall got %b want %b", ctl, C_DSTALL); end
    @(negedge CLK);
    dhit = 1'b1;
    #2;
    vectors++;
    if (ctl !== C_HALTIN) begin miscompares++; $display("FAIL halt_mem got %b want %b", ctl, C_HALTIN); end
    @(negedge CLK);
    idle_inputs();
    #2;
    vectors++;
    if ({ctl, halt} !== {C_DRAIN, 1'b0}) begin
      miscompares++; $display("FAIL drain got %b/%b want %b/0", ctl, halt, C_DRAIN);
    end
    @(negedge CLK);
    for (int i = 0; i < 12; i++) begin
      ihit = i[0]; exmem_branch_taken = i[1]; id_jump = i[2];
      #2;
      vectors++;
      if ({ctl, halt} !== {C_HALTED, 1'b1}) begin
        miscompares++; $display("FAIL halted_%0d got %b/%b want %b/1", i, ctl, halt, C_HALTED);
      end
      @(negedge CLK);
    end
    do_reset();
    #2;
    vectors++;
    if ({ctl, halt} !== {C_FLOW, 1'b0}) begin
      miscompares++; $display("FAIL halt_exit got %b/%b want %b/0", ctl, halt, C_FLOW);
    end
    @(negedge CLK);
  endtask

  task automatic test_watchdog();
    do_reset();
    exmem_dREN = 1'b1;
    repeat (3) @(negedge CLK);
    dhit = 1'b1;
    #2;
    vectors++;
    if (mem_timeout !== 1'b0) begin miscompares++; $display("FAIL wd_three got %b want 0", mem_timeout); end
    @(negedge CLK);
    dhit = 1'b0;
    #2;
    vectors++;
    if (mem_timeout !== 1'b0) begin miscompares++; $display("FAIL wd_cleared got %b want 0", mem_timeout); end
    repeat (3) @(negedge CLK);
    #2;
    vectors++;
    if (mem_timeout !== 1'b0) begin miscompares++; $display("FAIL wd_before got %b want 0", mem_timeout); end
    @(negedge CLK);
    dhit = 1'b1;
    #2;
    vectors++;
    if (mem_timeout !== 1'b1) begin miscompares++; $display("FAIL wd_set got %b want 1", mem_timeout); end
    @(negedge CLK);
    exmem_dREN = 1'b0;
    @(negedge CLK);
    #2;
    vectors++;
    if ({mem_timeout, ctl} !== {1'b1, C_FLOW}) begin
      miscompares++; $display("FAIL wd_sticky got %b/%b want 1/%b", mem_timeout, ctl, C_FLOW);
    end
    @(negedge CLK);
    exmem_dREN = 1'b1; dhit = 1'b0;
    #2;
    vectors++;
    if (ctl !== C_DSTALL) begin miscompares++; $display("FAIL wd_stall_same got %b want %b", ctl, C_DSTALL); end
    RST = 1'b1;
    #1;
    vectors++;
    if ({ctl, mem_timeout, stall_count} !== {C_BOOT, 1'b0, 32'd0}) begin
      miscompares++; $display("FAIL async_rst got %b/%b/%0d want %b/0/0", ctl, mem_timeout, stall_count, C_BOOT);
    end
    @(negedge CLK);
    RST = 1'b0;
    idle_inputs();
    #2;
    vectors++;
    if (ctl !== C_BOOT) begin miscompares++; $display("FAIL async_boot got %b want %b", ctl, C_BOOT); end
    @(negedge CLK);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_data_stall();
    test_loaduse();
    test_branch_jump();
    test_halt();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
